pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 126 ++++++++++++
 tb/tb_pc_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: selects the next fetch address each cycle and takes
// precise traps. Bit 31 of the PC is the kernel-mode bit. All address
// arithmetic is done on bits [30:0] and wraps modulo 2^31.
module pc_unit #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] jr_target,
  input  logic        irq,
  input  logic        illop,
  output logic [31:0] pc,
  output logic [30:0] rom_addr,
  output logic [31:0] pc_plus4,
  output logic        kernel,
  output logic        trap_wb,
  output logic [31:0] link_pc
);

  localparam logic [1:0] SRC_SEQ = 2'd0;
  localparam logic [1:0] SRC_BR  = 2'd1;
  localparam logic [1:0] SRC_J   = 2'd2;
  localparam logic [1:0] SRC_JR  = 2'd3;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        irq_pend_q;
  logic        irq_pend_d;
  logic        irq_dly_q;

  logic [30:0] br_off_s;
  logic [31:0] pc_norm_s;
  logic        irq_rise_s;
  logic        exc_take_s;
  logic        irq_take_s;

  // Present PC; while reset is held the visible PC is the reset vector.
  always_comb begin
    pc = RESET_VEC;
    if (reset) begin
      pc = pc_q;
    end else begin
      pc = RESET_VEC;
    end
    rom_addr = pc[30:0];
    kernel   = pc[31];
    pc_plus4 = {pc[31], pc[30:0] + 31'd4};
  end

  // Trap decision: exception beats interrupt; interrupts only leave user mode.
  always_comb begin
    irq_rise_s = irq & ~irq_dly_q;
    exc_take_s = reset & ~stall & illop;
    irq_take_s = reset & ~stall & ~illop & irq_pend_q & ~kernel;
    trap_wb    = exc_take_s | irq_take_s;
    link_pc    = pc_plus4;
    if (irq_take_s) begin
      // Interrupted instruction has not executed, so it is re-run on return.
      link_pc = pc;
    end else begin
      link_pc = pc_plus4;
    end
  end

  // Normal (non-trap) next-PC selection; JR can drop but never raise bit 31.
  always_comb begin
    br_off_s  = {{13{imm16[15]}}, imm16, 2'b00};
    pc_norm_s = pc_plus4;
    case (pc_src)
      SRC_SEQ: pc_norm_s = pc_plus4;
      SRC_BR: begin
        if (branch_taken) begin
          pc_norm_s = {pc[31], pc_plus4[30:0] + br_off_s};
        end else begin
          pc_norm_s = pc_plus4;
        end
      end
      SRC_J:   pc_norm_s = {pc[31], pc_plus4[30:28], target26, 2'b00};
      SRC_JR:  pc_norm_s = {pc[31] & jr_target[31], jr_target[30:0]};
      default: pc_norm_s = pc_plus4;
    endcase
  end

  // Next-state for PC and pending interrupt; a new edge wins over a clear.
  always_comb begin
    pc_d       = pc_q;
    irq_pend_d = irq_pend_q;
    if (stall) begin
      pc_d = pc_q;
    end else if (exc_take_s) begin
      pc_d = EXC_VEC;
    end else if (irq_take_s) begin
      pc_d = IRQ_VEC;
    end else begin
      pc_d = pc_norm_s;
    end
    if (irq_rise_s) begin
      irq_pend_d = 1'b1;
    end else if (irq_take_s) begin
      irq_pend_d = 1'b0;
    end else begin
      irq_pend_d = irq_pend_q;
    end
  end

  // State registers; irq edge tracking keeps running during stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= RESET_VEC;
      irq_pend_q <= 1'b0;
      irq_dly_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      irq_pend_q <= irq_pend_d;
      irq_dly_q  <= irq;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: sequential fetch, branch, jump, JR mode rules,
// interrupt/exception entry, stall behaviour and reset override.
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  pc_src;
  logic        branch_taken;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] jr_target;
  logic        irq;
  logic        illop;
  logic [31:0] pc;
  logic [30:0] rom_addr;
  logic [31:0] pc_plus4;
  logic        kernel;
  logic        trap_wb;
  logic [31:0] link_pc;

  int total_cnt = 0;
  int bad_cnt   = 0;

  pc_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .imm16        (imm16),
    .target26     (target26),
    .jr_target    (jr_target),
    .irq          (irq),
    .illop        (illop),
    .pc           (pc),
    .rom_addr     (rom_addr),
    .pc_plus4     (pc_plus4),
    .kernel       (kernel),
    .trap_wb      (trap_wb),
    .link_pc      (link_pc)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample a little after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Directed stimulus.
  initial begin
    reset = 1'b0; stall = 1'b0; pc_src = 2'd0; branch_taken = 1'b0;
    imm16 = 16'h0000; target26 = 26'h0; jr_target = 32'h0;
    irq = 1'b0; illop = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_val("rst_pc", pc, 32'h8000_0000);
    check_val("rst_rom", {1'b0, rom_addr}, 32'h0000_0000);
    check_val("rst_kernel", {31'd0, kernel}, 32'd1);
    check_val("rst_trap", {31'd0, trap_wb}, 32'd0);

    // Sequential fetch after release.
    illop = 1'b0; reset = 1'b1; #1;
    check_val("seq0_pc", pc, 32'h8000_0000);
    tick(); check_val("seq1_pc", pc, 32'h8000_0004); check_val("seq1_rom", {1'b0, rom_addr}, 32'h4);
    tick(); check_val("seq2_pc", pc, 32'h8000_0008); check_val("seq2_rom", {1'b0, rom_addr}, 32'h8);
    tick(); check_val("seq3_pc", pc, 32'h8000_000C); check_val("seq3_rom", {1'b0, rom_addr}, 32'hC);
    check_val("seq3_p4", pc_plus4, 32'h8000_0010);

    // JR: stays kernel, drops to user, cannot re-enter kernel.
    pc_src = 2'd3; jr_target = 32'h8000_00B0; tick();
    check_val("jr_kk_pc", pc, 32'h8000_00B0);
    jr_target = 32'h0000_0050; tick();
    check_val("jr_ku_pc", pc, 32'h0000_0050);
    check_val("jr_ku_kernel", {31'd0, kernel}, 32'd0);
    jr_target = 32'h8000_0100; tick();
    check_val("jr_uk_pc", pc, 32'h0000_0100);
    check_val("jr_uk_kernel", {31'd0, kernel}, 32'd0);

    // Branch taken / not taken, then jump.
    jr_target = 32'h0000_0010; tick();
    pc_src = 2'd1; branch_taken = 1'b1; imm16 = 16'hFFFD; tick();
    check_val("br_taken_pc", pc, 32'h0000_0008);
    pc_src = 2'd3; jr_target = 32'h0000_0010; tick();
    pc_src = 2'd1; branch_taken = 1'b0; tick();
    check_val("br_not_pc", pc, 32'h0000_0014);
    pc_src = 2'd2; target26 = 26'h000_0123; tick();
    check_val("jump_pc", pc, 32'h0000_048C);

    // User-mode interrupt.
    pc_src = 2'd3; jr_target = 32'h0000_0070; irq = 1'b1; tick();
    check_val("irq_u_pc", pc, 32'h0000_0070);
    check_val("irq_u_trap", {31'd0, trap_wb}, 32'd1);
    check_val("irq_u_link", link_pc, 32'h0000_0070);
    pc_src = 2'd0; tick();
    check_val("irq_u_vec", pc, 32'h8000_0004);
    check_val("irq_u_k_trap", {31'd0, trap_wb}, 32'd0);
    pc_src = 2'd3; jr_target = 32'h0000_0200; tick();
    check_val("irq_held_pc", pc, 32'h0000_0200);
    check_val("irq_held_trap", {31'd0, trap_wb}, 32'd0);

    // Exception from user, then interrupt pending through kernel mode.
    irq = 1'b0; pc_src = 2'd0; illop = 1'b1; #1;
    check_val("exc_u_trap", {31'd0, trap_wb}, 32'd1);
    check_val("exc_u_link", link_pc, 32'h0000_0204);
    tick();
    check_val("exc_vec_pc", pc, 32'h8000_0008);
    illop = 1'b0; pc_src = 2'd3; jr_target = 32'h8000_0010; tick();
    check_val("k_pc", pc, 32'h8000_0010);
    pc_src = 2'd0; irq = 1'b1; tick();
    irq = 1'b0;
    check_val("k_irq_trap0", {31'd0, trap_wb}, 32'd0);
    tick();
    check_val("k_irq_trap1", {31'd0, trap_wb}, 32'd0);
    pc_src = 2'd3; jr_target = 32'h0000_0040; tick();
    check_val("k_irq_pc", pc, 32'h0000_0040);
    check_val("k_irq_trap", {31'd0, trap_wb}, 32'd1);
    check_val("k_irq_link", link_pc, 32'h0000_0040);
    pc_src = 2'd0; tick();
    check_val("k_irq_vec", pc, 32'h8000_0004);

    // Exception beats pending interrupt; stall suppresses the trap.
    irq = 1'b1; tick();
    irq = 1'b0; pc_src = 2'd3; jr_target = 32'h0000_0020; tick();
    check_val("ei_pc", pc, 32'h0000_0020);
    illop = 1'b1; stall = 1'b1; #1;
    check_val("stall_trap", {31'd0, trap_wb}, 32'd0);
    tick();
    check_val("stall_pc", pc, 32'h0000_0020);
    stall = 1'b0; #1;
    check_val("ei_trap", {31'd0, trap_wb}, 32'd1);
    check_val("ei_link", link_pc, 32'h0000_0024);
    tick();
    check_val("ei_vec", pc, 32'h8000_0008);
    illop = 1'b0; pc_src = 2'd3; jr_target = 32'h0000_0030; tick();
    check_val("pend_kept_trap", {31'd0, trap_wb}, 32'd1);
    check_val("pend_kept_link", link_pc, 32'h0000_0030);
    pc_src = 2'd0; tick();
    check_val("pend_kept_vec", pc, 32'h8000_0004);

    // Address wrap keeps the kernel bit.
    pc_src = 2'd3; jr_target = 32'hFFFF_FFFC; tick();
    check_val("wrap_pc", pc, 32'hFFFF_FFFC);
    check_val("wrap_p4", pc_plus4, 32'h8000_0000);

    // Reset overrides stall.
    stall = 1'b1; reset = 1'b0; tick();
    check_val("rst_stall_pc", pc, 32'h8000_0000);
    check_val("rst_stall_trap", {31'd0, trap_wb}, 32'd0);
    reset = 1'b1; stall = 1'b0; #1;
    check_val("rst_rel_pc", pc, 32'h8000_0000);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
